// File: rtl/left_barrel_shifter_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : left_barrel_shifter_pipelined
// Description : Variable-amount left shifter / rotator built as a log2(N)
//               stage barrel pipeline. Stage k conditionally shifts (or
//               rotates) its operand left by 2^k. Valid/ready handshake on
//               both sides with full backpressure and one result per cycle.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               up_valid/up_ready - upstream handshake
//               up_data           - N-bit operand
//               up_shamt          - SW-bit shift amount
//               up_rotate         - 1 = rotate left, 0 = logical shift left
//               down_valid/down_ready - downstream handshake
//               down_data         - N-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module left_barrel_shifter_pipelined #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic          up_rotate,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    // Per-stage views of the pipeline registers, used to chain stages.
    logic          w_stg_valid [SW];
    logic [N-1:0]  w_stg_data  [SW];
    logic [SW-1:0] w_stg_shamt [SW];
    logic          w_stg_rot   [SW];
    logic          w_stg_ready [SW];

    for (genvar k = 0; k < SW; k++) begin : g_stage
        // 2^k is always below N because SW = clog2(N), so the rotate amount
        // (2^k mod N) never degenerates to zero.
        localparam int c_SHL_AMT = 1 << k;
        localparam int c_ROT_AMT = (1 << k) % N;

        logic         w_in_valid;
        logic [N-1:0] w_in_data;
        logic         w_in_bit;
        logic         w_in_rot;
        logic [N-1:0] data_d;
        logic         valid_q;
        logic [N-1:0] data_q;

        // The shift amount travels down the pipe already right-aligned, so
        // every stage only ever inspects bit 0 of what it receives.
        if (k == 0) begin : g_src_up
            assign w_in_valid = up_valid;
            assign w_in_data  = up_data;
            assign w_in_bit   = up_shamt[0];
            assign w_in_rot   = up_rotate;
        end else begin : g_src_stage
            assign w_in_valid = w_stg_valid[k-1];
            assign w_in_data  = w_stg_data[k-1];
            assign w_in_bit   = w_stg_shamt[k-1][0];
            assign w_in_rot   = w_stg_rot[k-1];
        end

        always_comb begin
            data_d = w_in_data;
            if (w_in_bit) begin
                if (w_in_rot) begin
                    data_d = (w_in_data << c_ROT_AMT) | (w_in_data >> (N - c_ROT_AMT));
                end else begin
                    data_d = w_in_data << c_SHL_AMT;
                end
            end
        end

        // A stage can load when empty or when its content moves on this cycle.
        if (k == SW - 1) begin : g_rdy_out
            assign w_stg_ready[k] = !valid_q || down_ready;
        end else begin : g_rdy_chain
            assign w_stg_ready[k] = !valid_q || w_stg_ready[k+1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (w_stg_ready[k]) begin
                valid_q <= w_in_valid;
                if (w_in_valid) begin
                    data_q <= data_d;
                end
            end
        end

        assign w_stg_valid[k] = valid_q;
        assign w_stg_data[k]  = data_q;

        // The last stage has no successor, so the control fields stop here.
        if (k < SW - 1) begin : g_fwd
            logic [SW-1:0] shamt_d;
            logic [SW-1:0] shamt_q;
            logic          rot_q;

            if (k == 0) begin : g_rest_up
                assign shamt_d = up_shamt >> 1;
            end else begin : g_rest_stage
                assign shamt_d = w_stg_shamt[k-1] >> 1;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shamt_q <= '0;
                    rot_q   <= 1'b0;
                end else if (w_stg_ready[k] && w_in_valid) begin
                    shamt_q <= shamt_d;
                    rot_q   <= w_in_rot;
                end
            end

            assign w_stg_shamt[k] = shamt_q;
            assign w_stg_rot[k]   = rot_q;
        end else begin : g_nofwd
            assign w_stg_shamt[k] = '0;
            assign w_stg_rot[k]   = 1'b0;
        end
    end

    assign up_ready   = w_stg_ready[0];
    assign down_valid = w_stg_valid[SW-1];
    assign down_data  = w_stg_data[SW-1];

endmodule
`default_nettype wire

// File: tb/tb_left_barrel_shifter_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_left_barrel_shifter_pipelined
// Description : Self-checking bench for left_barrel_shifter_pipelined (N=8
//               main instance, N=6 side instance) with a reference model and
//               a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_left_barrel_shifter_pipelined;

    logic       clk;
    logic       rst;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic [2:0] up_shamt;
    logic       up_rotate;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;

    logic       u6_up_valid;
    logic       u6_up_ready;
    logic [5:0] u6_up_data;
    logic [2:0] u6_up_shamt;
    logic       u6_up_rotate;
    logic       u6_down_valid;
    logic [5:0] u6_down_data;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    bit mon_en   = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] exp_q [$];

    left_barrel_shifter_pipelined #(.N(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_shamt   (up_shamt),
        .up_rotate  (up_rotate),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    left_barrel_shifter_pipelined #(.N(6)) u_dut6 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (u6_up_valid),
        .up_ready   (u6_up_ready),
        .up_data    (u6_up_data),
        .up_shamt   (u6_up_shamt),
        .up_rotate  (u6_up_rotate),
        .down_valid (u6_down_valid),
        .down_ready (1'b1),
        .down_data  (u6_down_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the shift/rotate definition.
    function automatic longint unsigned ref_shift(input int n, input longint unsigned d,
                                                  input int s, input bit rot);
        longint unsigned mask = (64'd1 << n) - 64'd1;
        int r;
        d = d & mask;
        if (rot) begin
            r = s % n;
            return ((d << r) | (d >> (n - r))) & mask;
        end
        if (s >= n) return 0;
        return (d << s) & mask;
    endfunction

    // Scoreboard: results must match the model queue head whenever presented.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else if (mon_en) begin
            if (prev_stall) check_eq("hold_valid", {63'd0, down_valid}, 64'd1);
            if (down_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid", {63'd0, down_valid}, 64'd0);
                end else begin
                    check_eq("result", {56'd0, down_data}, {56'd0, exp_q[0]});
                    if (down_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            prev_stall <= down_valid && !down_ready;
            if (up_valid && up_ready)
                exp_q.push_back(8'(ref_shift(8, up_data, int'(up_shamt), up_rotate)));
        end
    end

    task automatic rand_item();
        up_data   = 8'($urandom);
        up_shamt  = 3'($urandom);
        up_rotate = 1'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // One directed transaction on an empty pipe; checks latency and value.
    task automatic directed(input string tag, input logic [7:0] d, input logic [2:0] s,
                            input logic r, input logic [7:0] exp);
        int lat = 0;
        up_valid = 1'b1; up_data = d; up_shamt = s; up_rotate = r;
        @(negedge clk);
        check_eq({tag, "_ready"}, {63'd0, up_ready}, 64'd1);
        @(posedge clk); #1;
        up_valid = 1'b0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (down_valid) break;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd3);
        check_eq({tag, "_data"}, {56'd0, down_data}, {56'd0, exp});
        @(negedge clk);
        check_eq({tag, "_pulse"}, {63'd0, down_valid}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic directed6(input string tag, input logic rot, input logic [5:0] exp);
        int c = 0;
        u6_up_valid = 1'b1; u6_up_data = 6'b110001; u6_up_shamt = 3'd7; u6_up_rotate = rot;
        @(posedge clk); #1;
        u6_up_valid = 1'b0;
        while (c < 10 && !u6_down_valid) begin
            @(negedge clk);
            c++;
        end
        check_eq({tag, "_valid"}, {63'd0, u6_down_valid}, 64'd1);
        check_eq({tag, "_data"}, {58'd0, u6_down_data}, {58'd0, exp});
        check_eq({tag, "_model"}, {58'd0, exp}, ref_shift(6, 64'b110001, 7, rot));
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int out0;
        int c;
        bit took;
        rst = 1'b1;
        up_valid = 1'b0; up_data = '0; up_shamt = '0; up_rotate = 1'b0;
        down_ready = 1'b1;
        u6_up_valid = 1'b0; u6_up_data = '0; u6_up_shamt = '0; u6_up_rotate = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_down_valid", {63'd0, down_valid}, 64'd0);
        check_eq("rst_down_data", {56'd0, down_data}, 64'd0);
        check_eq("rst_up_ready", {63'd0, up_ready}, 64'd1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Directed shift / rotate vectors.
        directed("lsl3",  8'b1011_0011, 3'd3, 1'b0, 8'b1001_1000);
        directed("rol3",  8'b1011_0011, 3'd3, 1'b1, 8'b1001_1101);
        directed("rol0",  8'b1011_0011, 3'd0, 1'b1, 8'b1011_0011);
        directed("lsl7",  8'b1011_0011, 3'd7, 1'b0, 8'b1000_0000);

        // Non-power-of-two width.
        directed6("n6_rol7", 1'b1, 6'b100011);
        directed6("n6_lsl7", 1'b0, 6'b000000);

        // Back-to-back streaming.
        out0 = n_out;
        acc = 0;
        c = 0;
        up_valid = 1'b1;
        rand_item();
        while (acc < 16 && c < 40) begin
            @(negedge clk);
            check_eq("stream_up_ready", {63'd0, up_ready}, 64'd1);
            took = up_ready;
            if (took) acc++;
            @(posedge clk); #1;
            if (took) rand_item();
            c++;
        end
        up_valid = 1'b0;
        wait_drain(20);
        check_eq("stream_count", 64'(n_out - out0), 64'd16);

        // Backpressure: capacity is exactly SW=3.
        out0 = n_out;
        acc = 0;
        down_ready = 1'b0;
        up_valid = 1'b1;
        rand_item();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            took = up_ready;
            if (took) acc++;
            @(posedge clk); #1;
            if (took) rand_item();
        end
        check_eq("bp_accepted", 64'(acc), 64'd3);
        @(negedge clk);
        check_eq("bp_full_ready", {63'd0, up_ready}, 64'd0);
        check_eq("bp_full_valid", {63'd0, down_valid}, 64'd1);
        @(posedge clk); #1;
        down_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", {63'd0, up_ready}, 64'd1);
        took = up_ready;
        if (took) acc++;
        c = 0;
        while (acc < 5 && c < 20) begin
            @(posedge clk); #1;
            if (took) rand_item();
            @(negedge clk);
            took = up_ready;
            if (took) acc++;
            c++;
        end
        @(posedge clk); #1;
        up_valid = 1'b0;
        wait_drain(20);
        check_eq("bp_count", 64'(n_out - out0), 64'd5);

        // Random traffic with random backpressure.
        took = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!up_valid || took) begin
                up_valid = ($urandom_range(3) != 0);
                rand_item();
            end
            down_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            took = up_valid && up_ready;
            @(posedge clk); #1;
        end
        up_valid = 1'b0;
        down_ready = 1'b1;
        wait_drain(20);

        // Asynchronous reset with three transactions in flight.
        down_ready = 1'b0;
        up_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_item();
            @(posedge clk); #1;
        end
        up_valid = 1'b0;
        @(posedge clk); #3;
        check_eq("pre_rst_valid", {63'd0, down_valid}, 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("async_rst_valid", {63'd0, down_valid}, 64'd0);
        check_eq("async_rst_data", {56'd0, down_data}, 64'd0);
        check_eq("async_rst_ready", {63'd0, up_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        down_ready = 1'b1;
        out0 = n_out;
        repeat (10) @(posedge clk);
        #1;
        check_eq("post_rst_no_stale", 64'(n_out - out0), 64'd0);
        directed("post_rst", 8'b0000_0001, 3'd5, 1'b1, 8'b0010_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/left_barrel_shifter_pipelined.md
Name: left_barrel_shifter_pipelined

Overview:
Variable-amount left shifter/rotator. It is the sequential, left-direction counterpart of the team's fixed right-shift blocks. A log2(N)-stage barrel pipeline; stage k conditionally shifts by 2^k. Valid/ready handshake on both sides with full backpressure, sustaining one result per cycle. Sits in the arithmetic datapath ahead of normalisation/multiply logic.

Parameters:
N, 8, data width in bits; legal values are N >= 2 (need not be a power of two).
SW, $clog2(N), shift-amount width and pipeline depth (stage count); derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
up_valid  input  1  upstream presents a transaction.
up_ready  output  1  shifter can accept this cycle.
up_data  input  N  operand.
up_shamt  input  SW  shift amount, 0 .. 2^SW-1.
up_rotate  input  1  1 = rotate left; 0 = logical shift left with zero fill.
down_valid  output  1  result available.
down_ready  input  1  downstream accepts the result.
down_data  output  N  result.

Behaviour:
- Transfer rule: a transfer occurs on a clock edge where valid && ready on that interface.
- Up-side rule: once up_valid is high, the source holds up_data, up_shamt and up_rotate stable until the transfer.
- Down-side rule: down_valid and down_data stay stable while down_valid && !down_ready.
- Stage registers: stage k (k = 0..SW-1) holds valid_k, data_k, the remaining shamt bits [SW-1:k+1], and rotate_k.
- Stage k shift: when shamt bit k is set, stage k shifts its input left by 2^k.
  - Logical mode: vacated LSBs are filled with 0.
  - Rotate mode: MSBs wrap into the LSBs; the rotate amount is 2^k mod N.
- Output mapping: down_valid = valid_{SW-1}; down_data = data_{SW-1}.
- Per-stage ready: stage k loads when !valid_k, or when stage k+1 (the output for the last stage) takes its current content in the same cycle.
- up_ready = ready of stage 0. This is a combinational ready chain from down_ready; there are no bubbles.
- Latency: a transfer accepted at edge t gives down_valid high after edge t+SW-1, i.e. the result is visible SW cycles after acceptance. Throughput is 1 per cycle with down_ready held high.
- Arithmetic rules, with s = up_shamt:
  - Logical mode: result = (up_data << s) truncated to N bits; s >= N gives 0.
  - Rotate mode: result = rotl(up_data, s mod N).
- Ordering: results leave in acceptance order; no reordering and no drop.
- Full condition: all SW stages valid and down_ready low gives up_ready = 0. Capacity is exactly SW transactions.
- Simultaneous events: when the output is consumed and a new input is accepted in the same cycle, every stage advances and occupancy is unchanged.
- Empty condition: all valid_k = 0, so down_valid = 0 and up_ready = 1 regardless of down_ready.
- Reset: asynchronous assert clears all valid_k and data_k/shamt/rotate registers to 0. Outputs after reset: down_valid=0, down_data=0, up_ready=1. In-flight transactions are discarded; there is no partial output. Deassertion is synchronous to clk in the surrounding design.
- Idle hold: inputs are ignored when up_valid=0; stage registers are not loaded when their valid input is 0.

Test Plan:
- Logical shift, N=8, SW=3, down_ready=1: up_data=8'b1011_0011, shamt=3, rotate=0 → down_valid pulses 3 cycles after acceptance with down_data=8'b1001_1000.
- Rotate: same operand, shamt=3, rotate=1 → 8'b1001_1101. Then shamt=0 → 8'b1011_0011 unchanged. Then shamt=7 rotate=0 → 8'b1000_0000.
- Back-to-back streaming: send 16 random operands with up_valid held high and down_ready=1 → one result per cycle, in order, matching the reference model. up_ready stays 1 throughout.
- Backpressure: down_ready=0, offer 5 transactions → exactly 3 are accepted, then up_ready=0. down_data stays stable while stalled. Raise down_ready → 5 results in order, and up_ready returns to 1 on the first consuming cycle.
- Non-power-of-two width, N=6 (SW=3): data=6'b110001, shamt=7.
  - rotate=1 → rotl by 1 = 6'b100011.
  - rotate=0 → 6'b000000.
- Reset mid-operation: 3 transactions in flight, down_ready=0, assert rst asynchronously between edges → down_valid=0 and down_data=0 immediately, up_ready=1. After release, no stale result ever appears.
